// File: rtl/pcie_tx_arb_pkg.sv
// Shared types and constants for the PCIe TX arbiter slice.
package pcie_tx_arb_pkg;

    localparam int unsigned CNT_W    = 32;
    localparam int unsigned NUM_SRC  = 2;
    localparam int unsigned SRC_CMPL = 0;
    localparam int unsigned SRC_DMA  = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } arb_state_e;

    // Per-beat sideband carried alongside tdata/tkeep
    typedef struct packed {
        logic tlast;
        logic tvalid;
        logic tsrc_dsc;
    } tx_ctl_t;

endpackage

// File: rtl/pcie_tx_arb_if.sv
// Source-side and core-side AXI-stream TX signals of the arbiter.
interface pcie_tx_arb_if #(
    parameter int unsigned C_DATA_WIDTH = 128,
    parameter int unsigned KEEP_WIDTH   = C_DATA_WIDTH / 8
);
    logic                    src0_req;
    logic                    src0_ack;
    logic                    src0_other_req;
    logic [C_DATA_WIDTH-1:0] src0_tdata;
    logic [KEEP_WIDTH-1:0]   src0_tkeep;
    logic                    src0_tlast;
    logic                    src0_tvalid;
    logic                    src0_tsrc_dsc;
    logic                    src0_tready;

    logic                    src1_req;
    logic                    src1_ack;
    logic                    src1_other_req;
    logic [C_DATA_WIDTH-1:0] src1_tdata;
    logic [KEEP_WIDTH-1:0]   src1_tkeep;
    logic                    src1_tlast;
    logic                    src1_tvalid;
    logic                    src1_tsrc_dsc;
    logic                    src1_tready;

    logic [C_DATA_WIDTH-1:0] s_axis_tx_tdata;
    logic [KEEP_WIDTH-1:0]   s_axis_tx_tkeep;
    logic                    s_axis_tx_tlast;
    logic                    s_axis_tx_tvalid;
    logic                    tx_src_dsc;
    logic                    s_axis_tx_tready;

    // Arbiter side
    modport slave (
        input  src0_req, src0_tdata, src0_tkeep, src0_tlast, src0_tvalid, src0_tsrc_dsc,
        input  src1_req, src1_tdata, src1_tkeep, src1_tlast, src1_tvalid, src1_tsrc_dsc,
        input  s_axis_tx_tready,
        output src0_ack, src0_other_req, src0_tready,
        output src1_ack, src1_other_req, src1_tready,
        output s_axis_tx_tdata, s_axis_tx_tkeep, s_axis_tx_tlast, s_axis_tx_tvalid, tx_src_dsc
    );

    // Sources plus core side
    modport master (
        output src0_req, src0_tdata, src0_tkeep, src0_tlast, src0_tvalid, src0_tsrc_dsc,
        output src1_req, src1_tdata, src1_tkeep, src1_tlast, src1_tvalid, src1_tsrc_dsc,
        output s_axis_tx_tready,
        input  src0_ack, src0_other_req, src0_tready,
        input  src1_ack, src1_other_req, src1_tready,
        input  s_axis_tx_tdata, s_axis_tx_tkeep, s_axis_tx_tlast, s_axis_tx_tvalid, tx_src_dsc
    );
endinterface

// File: rtl/pcie_tx_mux.sv
// Combinational data/tready steering between the two TX sources and the core.
module pcie_tx_mux
    import pcie_tx_arb_pkg::*;
#(
    parameter int unsigned C_DATA_WIDTH = 128,
    parameter int unsigned KEEP_WIDTH   = C_DATA_WIDTH / 8
) (
    input  logic                    sel0,
    input  logic                    sel1,
    input  logic [C_DATA_WIDTH-1:0] src0_tdata,
    input  logic [KEEP_WIDTH-1:0]   src0_tkeep,
    input  tx_ctl_t                 src0_ctl,
    input  logic [C_DATA_WIDTH-1:0] src1_tdata,
    input  logic [KEEP_WIDTH-1:0]   src1_tkeep,
    input  tx_ctl_t                 src1_ctl,
    input  logic                    core_tready,
    output logic [C_DATA_WIDTH-1:0] tx_tdata,
    output logic [KEEP_WIDTH-1:0]   tx_tkeep,
    output tx_ctl_t                 tx_ctl,
    output logic                    src0_tready,
    output logic                    src1_tready
);

    // Nothing reaches the core unless a source holds the grant
    always_comb begin
        tx_tdata    = '0;
        tx_tkeep    = '0;
        tx_ctl      = '0;
        src0_tready = 1'b0;
        src1_tready = 1'b0;
        if (sel0) begin
            tx_tdata    = src0_tdata;
            tx_tkeep    = src0_tkeep;
            tx_ctl      = src0_ctl;
            src0_tready = core_tready;
        end else if (sel1) begin
            tx_tdata    = src1_tdata;
            tx_tkeep    = src1_tkeep;
            tx_ctl      = src1_ctl;
            src1_tready = core_tready;
        end
    end

endmodule

// File: rtl/pcie_tx_arb.sv
// Two-source TX link arbiter: round-robin on ties, packet-atomic grants, IDLE gap between grants.
module pcie_tx_arb
    import pcie_tx_arb_pkg::*;
#(
    parameter int unsigned C_DATA_WIDTH = 128,
    parameter int unsigned KEEP_WIDTH   = C_DATA_WIDTH / 8
) (
    input  logic             clk,
    input  logic             sys_rst,
    pcie_tx_arb_if.slave     bus,
    output logic [CNT_W-1:0] grant_cnt0,
    output logic [CNT_W-1:0] grant_cnt1
);

    arb_state_e              state, state_nxt;
    logic                    last_gnt;
    logic                    in_pkt, in_pkt_nxt;
    logic                    beat_c;
    logic                    sel0_c, sel1_c;
    tx_ctl_t                 src0_ctl, src1_ctl, tx_ctl;
    logic [C_DATA_WIDTH-1:0] tx_tdata;
    logic [KEEP_WIDTH-1:0]   tx_tkeep;
    logic                    src0_tready, src1_tready;

    assign src0_ctl = '{tlast: bus.src0_tlast, tvalid: bus.src0_tvalid, tsrc_dsc: bus.src0_tsrc_dsc};
    assign src1_ctl = '{tlast: bus.src1_tlast, tvalid: bus.src1_tvalid, tsrc_dsc: bus.src1_tsrc_dsc};

    pcie_tx_mux #(
        .C_DATA_WIDTH (C_DATA_WIDTH),
        .KEEP_WIDTH   (KEEP_WIDTH)
    ) u_mux (
        .sel0        (sel0_c),
        .sel1        (sel1_c),
        .src0_tdata  (bus.src0_tdata),
        .src0_tkeep  (bus.src0_tkeep),
        .src0_ctl    (src0_ctl),
        .src1_tdata  (bus.src1_tdata),
        .src1_tkeep  (bus.src1_tkeep),
        .src1_ctl    (src1_ctl),
        .core_tready (bus.s_axis_tx_tready),
        .tx_tdata    (tx_tdata),
        .tx_tkeep    (tx_tkeep),
        .tx_ctl      (tx_ctl),
        .src0_tready (src0_tready),
        .src1_tready (src1_tready)
    );

    assign bus.s_axis_tx_tdata  = tx_tdata;
    assign bus.s_axis_tx_tkeep  = tx_tkeep;
    assign bus.s_axis_tx_tlast  = tx_ctl.tlast;
    assign bus.s_axis_tx_tvalid = tx_ctl.tvalid;
    assign bus.tx_src_dsc       = tx_ctl.tsrc_dsc;
    assign bus.src0_tready      = src0_tready;
    assign bus.src1_tready      = src1_tready;

    assign beat_c = tx_ctl.tvalid & bus.s_axis_tx_tready;

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    // Release only once the packet boundary is reached, counting this cycle's beat
    always_comb begin
        state_nxt  = state;
        in_pkt_nxt = beat_c ? ~tx_ctl.tlast : in_pkt;
        case (state)
            ST_IDLE: begin
                if (bus.src0_req && bus.src1_req) state_nxt = last_gnt ? ST_GNT0 : ST_GNT1;
                else if (bus.src0_req)            state_nxt = ST_GNT0;
                else if (bus.src1_req)            state_nxt = ST_GNT1;
            end
            ST_GNT0: if (!bus.src0_req && !in_pkt_nxt) state_nxt = ST_IDLE;
            ST_GNT1: if (!bus.src1_req && !in_pkt_nxt) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        sel0_c = 1'b0;
        sel1_c = 1'b0;
        case (state)
            ST_GNT0: sel0_c = 1'b1;
            ST_GNT1: sel1_c = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            in_pkt             <= 1'b0;
            last_gnt           <= 1'b1;
            bus.src0_ack       <= 1'b0;
            bus.src1_ack       <= 1'b0;
            bus.src0_other_req <= 1'b0;
            bus.src1_other_req <= 1'b0;
        end else begin
            in_pkt             <= in_pkt_nxt;
            bus.src0_ack       <= (state_nxt == ST_GNT0);
            bus.src1_ack       <= (state_nxt == ST_GNT1);
            bus.src0_other_req <= bus.src1_req;
            bus.src1_other_req <= bus.src0_req;
            if (state == ST_IDLE && state_nxt == ST_GNT0) last_gnt <= 1'b0;
            if (state == ST_IDLE && state_nxt == ST_GNT1) last_gnt <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else if (state == ST_IDLE) begin
            if (state_nxt == ST_GNT0) grant_cnt0 <= grant_cnt0 + CNT_W'(1);
            if (state_nxt == ST_GNT1) grant_cnt1 <= grant_cnt1 + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pcie_tx_arb.sv
// Directed bench for pcie_tx_arb with a grant-ownership model compared every cycle.
module tb_pcie_tx_arb;
    import pcie_tx_arb_pkg::*;

    localparam int unsigned DW = 128;
    localparam int unsigned KW = DW / 8;

    logic        clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic [31:0] grant_cnt0, grant_cnt1;

    pcie_tx_arb_if #(.C_DATA_WIDTH(DW), .KEEP_WIDTH(KW)) bus ();

    pcie_tx_arb #(.C_DATA_WIDTH(DW), .KEEP_WIDTH(KW)) dut (
        .clk        (clk),
        .sys_rst    (sys_rst),
        .bus        (bus.slave),
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1)
    );

    always #5 clk = ~clk;

    logic          req [2];
    logic          vld [2];
    logic          lst [2];
    logic          dsc [2];
    logic [DW-1:0] dat [2];
    logic [KW-1:0] kp  [2];
    logic          core_rdy;

    assign bus.src0_req = req[0];  assign bus.src1_req = req[1];
    assign bus.src0_tvalid = vld[0]; assign bus.src1_tvalid = vld[1];
    assign bus.src0_tlast = lst[0];  assign bus.src1_tlast = lst[1];
    assign bus.src0_tsrc_dsc = dsc[0]; assign bus.src1_tsrc_dsc = dsc[1];
    assign bus.src0_tdata = dat[0];  assign bus.src1_tdata = dat[1];
    assign bus.src0_tkeep = kp[0];   assign bus.src1_tkeep = kp[1];
    assign bus.s_axis_tx_tready = core_rdy;

    int errs = 0;
    int checks = 0;
    logic [DW:0] seen [$];

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: who owns the link (-1 = nobody), whether a packet is open, round-robin memory
    int          m_own = -1;
    logic        m_last = 1'b1;
    logic        m_pkt = 1'b0;
    logic [31:0] m_cnt [2] = '{32'd0, 32'd0};
    logic        m_oreq [2] = '{1'b0, 1'b0};

    function automatic logic open_after(int s);
        return (vld[s] && core_rdy) ? !lst[s] : m_pkt;
    endfunction

    function automatic int winner();
        if (req[0] && req[1]) return m_last ? 0 : 1;
        return req[0] ? 0 : 1;
    endfunction

    always @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            m_own <= -1; m_last <= 1'b1; m_pkt <= 1'b0;
            m_cnt[0] <= 32'd0; m_cnt[1] <= 32'd0;
            m_oreq[0] <= 1'b0; m_oreq[1] <= 1'b0;
        end else begin
            m_oreq[0] <= req[1];
            m_oreq[1] <= req[0];
            if (m_own >= 0) begin
                m_pkt <= open_after(m_own);
                if (!req[m_own] && !open_after(m_own)) m_own <= -1;
            end else if (req[0] || req[1]) begin
                m_own <= winner();
                m_last <= (winner() == 1);
                m_cnt[winner()] <= m_cnt[winner()] + 32'd1;
            end
        end
    end

    function automatic logic gv();
        return m_own >= 0;
    endfunction
    function automatic int gk();
        return (m_own >= 0) ? m_own : 0;
    endfunction

    always @(negedge clk) begin
        chk("ack0", DW'(bus.src0_ack), DW'(m_own == 0));
        chk("ack1", DW'(bus.src1_ack), DW'(m_own == 1));
        chk("other_req0", DW'(bus.src0_other_req), DW'(m_oreq[0]));
        chk("other_req1", DW'(bus.src1_other_req), DW'(m_oreq[1]));
        chk("tvalid", DW'(bus.s_axis_tx_tvalid), DW'(gv() ? vld[gk()] : 1'b0));
        chk("tlast", DW'(bus.s_axis_tx_tlast), DW'(gv() ? lst[gk()] : 1'b0));
        chk("tsrc_dsc", DW'(bus.tx_src_dsc), DW'(gv() ? dsc[gk()] : 1'b0));
        chk("tdata", bus.s_axis_tx_tdata, gv() ? dat[gk()] : '0);
        chk("tkeep", DW'(bus.s_axis_tx_tkeep), DW'(gv() ? kp[gk()] : '0));
        chk("tready0", DW'(bus.src0_tready), DW'(m_own == 0 && core_rdy));
        chk("tready1", DW'(bus.src1_tready), DW'(m_own == 1 && core_rdy));
        chk("grant_cnt0", DW'(grant_cnt0), DW'(m_cnt[0]));
        chk("grant_cnt1", DW'(grant_cnt1), DW'(m_cnt[1]));
        if (bus.s_axis_tx_tvalid && bus.s_axis_tx_tready)
            seen.push_back({bus.s_axis_tx_tlast, bus.s_axis_tx_tdata});
    end

    function automatic logic ackv(int s);
        return (s == 0) ? bus.src0_ack : bus.src1_ack;
    endfunction
    function automatic logic rdyv(int s);
        return (s == 0) ? bus.src0_tready : bus.src1_tready;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int s, input logic v, input logic l, input logic [DW-1:0] d);
        vld[s] = v;
        lst[s] = l;
        dat[s] = d;
        kp[s]  = l ? KW'(16'h00ff) : '1;
        dsc[s] = v & d[0] & d[1];
    endtask

    task automatic wait_ack(input int s);
        int n = 0;
        while (!ackv(s)) begin
            tick();
            n++;
            if (n > 50) begin
                checks++; errs++;
                $display("FAIL wait_ack%0d: no grant within 50 cycles", s);
                break;
            end
        end
    endtask

    // Sends n beats from source s; drops req after beat drop_after; stalls core 3 cycles before beat stall_at
    task automatic send_pkt(input int s, input int n, input logic [DW-1:0] base,
                            input int drop_after, input int stall_at);
        seen.delete();
        for (int i = 0; i < n; i++) begin
            set_src(s, 1'b1, (i == n - 1), base + DW'(i));
            if (i == stall_at) begin
                core_rdy = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    chk("stall_tready", DW'(rdyv(s)), DW'(0));
                    chk("stall_other_tready", DW'(rdyv(1 - s)), DW'(0));
                    tick();
                end
                core_rdy = 1'b1;
            end
            @(negedge clk);
            chk("ack_held", DW'(ackv(s)), DW'(1));
            tick();
            if (i + 1 == drop_after) req[s] = 1'b0;
        end
        set_src(s, 1'b0, 1'b0, '0);
        chk("beat_count", DW'(seen.size()), DW'(n));
        for (int i = 0; i < seen.size() && i < n; i++) begin
            chk("beat_data", seen[i][DW-1:0], base + DW'(i));
            chk("beat_last", DW'(seen[i][DW]), DW'(i == n - 1));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int s = 0; s < 2; s++) begin
            req[s] = 1'b0;
            set_src(s, 1'b0, 1'b0, '0);
        end
        core_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack0", DW'(bus.src0_ack), DW'(0));
        chk("rst_cnt1", DW'(grant_cnt1), DW'(0));
        chk("rst_tvalid", DW'(bus.s_axis_tx_tvalid), DW'(0));
        sys_rst = 1'b0;

        // Single requester, 5-beat packet
        req[1] = 1'b1;
        @(negedge clk);
        chk("t1_ack_before", DW'(bus.src1_ack), DW'(0));
        tick();
        chk("t1_ack_after", DW'(bus.src1_ack), DW'(1));
        send_pkt(1, 5, DW'(128'h100), 99, 99);
        req[1] = 1'b0;
        tick();
        chk("t1_release", DW'(bus.src1_ack), DW'(0));
        chk("t1_cnt1", DW'(grant_cnt1), DW'(1));

        // Simultaneous requests after reset: src0 first, one IDLE cycle, then src1
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        req[0] = 1'b1;
        req[1] = 1'b1;
        tick();
        chk("t2_ack0", DW'(bus.src0_ack), DW'(1));
        chk("t2_ack1", DW'(bus.src1_ack), DW'(0));
        send_pkt(0, 2, DW'(128'h200), 2, 99);
        tick();
        chk("t2_gap_ack0", DW'(bus.src0_ack), DW'(0));
        chk("t2_gap_ack1", DW'(bus.src1_ack), DW'(0));
        tick();
        chk("t2_ack1_next", DW'(bus.src1_ack), DW'(1));
        send_pkt(1, 2, DW'(128'h300), 2, 99);
        tick();

        // req dropped mid-packet: grant held until tlast beat, idle right after
        set_src(0, 1'b1, 1'b0, DW'(128'hbad0));
        req[1] = 1'b1;
        wait_ack(1);
        send_pkt(1, 5, DW'(128'h400), 2, 99);
        chk("t3_release", DW'(bus.src1_ack), DW'(0));
        set_src(0, 1'b0, 1'b0, '0);

        // Core back-pressure for 3 cycles mid-packet
        req[0] = 1'b1;
        wait_ack(0);
        send_pkt(0, 5, DW'(128'h500), 5, 2);
        tick();
        chk("t4_release", DW'(bus.src0_ack), DW'(0));

        // src0 requests while src1 owns the link
        req[1] = 1'b1;
        wait_ack(1);
        req[0] = 1'b1;
        @(negedge clk);
        chk("t5_oreq_before", DW'(bus.src1_other_req), DW'(0));
        tick();
        chk("t5_oreq", DW'(bus.src1_other_req), DW'(1));
        send_pkt(1, 3, DW'(128'h600), 3, 99);
        chk("t5_no_preempt", DW'(bus.src0_ack), DW'(0));
        tick();
        chk("t5_gap_ack0", DW'(bus.src0_ack), DW'(0));
        chk("t5_gap_ack1", DW'(bus.src1_ack), DW'(0));
        tick();
        chk("t5_ack0", DW'(bus.src0_ack), DW'(1));
        req[0] = 1'b0;
        tick();
        chk("t5_release", DW'(bus.src0_ack), DW'(0));
        chk("t5_cnt0", DW'(grant_cnt0), DW'(3));
        chk("t5_cnt1", DW'(grant_cnt1), DW'(3));

        // Reset during beat 3 of a packet
        req[0] = 1'b1;
        wait_ack(0);
        for (int i = 0; i < 2; i++) begin
            set_src(0, 1'b1, 1'b0, DW'(128'h700) + DW'(i));
            tick();
        end
        set_src(0, 1'b1, 1'b0, DW'(128'h702));
        #2;
        sys_rst = 1'b1;
        #1;
        chk("t6_ack0", DW'(bus.src0_ack), DW'(0));
        chk("t6_tvalid", DW'(bus.s_axis_tx_tvalid), DW'(0));
        chk("t6_tdata", bus.s_axis_tx_tdata, '0);
        chk("t6_tready0", DW'(bus.src0_tready), DW'(0));
        chk("t6_cnt0", DW'(grant_cnt0), DW'(0));
        chk("t6_oreq1", DW'(bus.src1_other_req), DW'(0));
        req[0] = 1'b0;
        set_src(0, 1'b0, 1'b0, '0);
        @(posedge clk);
        #1;
        sys_rst = 1'b0;
        req[1] = 1'b1;
        tick();
        chk("t6_regrant", DW'(bus.src1_ack), DW'(1));
        chk("t6_cnt1", DW'(grant_cnt1), DW'(1));
        req[1] = 1'b0;
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/pcie_tx_arb.md
PCIE_TX_ARB -- requirements
Module: pcie_tx_arb

Interface
REQ-001 Parameter C_DATA_WIDTH, default 128, TX data width in bits.
REQ-002 Parameter KEEP_WIDTH, default C_DATA_WIDTH/8, tkeep width in bits.
REQ-003 Clocking and reset: one clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  core user clock; all logic on rising edge.
REQ-005 sys_rst  in  1  asynchronous active-high reset.
REQ-006 srcN_req  in  1  source N (N=0 completer, N=1 DMA test engine) requests the TX link.
REQ-007 srcN_ack  out  1  registered grant to source N.
REQ-008 srcN_other_req  out  1  registered; high while the other source requests, telling N to yield.
REQ-009 srcN_tdata  in  C_DATA_WIDTH  source N TX data.
REQ-010 srcN_tkeep  in  KEEP_WIDTH  source N byte enables.
REQ-011 srcN_tlast, srcN_tvalid, srcN_tsrc_dsc  in  1  source N framing and discontinue.
REQ-012 srcN_tready  out  1  core tready gated to source N.
REQ-013 s_axis_tx_tdata, s_axis_tx_tkeep  out  C_DATA_WIDTH, KEEP_WIDTH  data and byte enables to the PCIe core.
REQ-014 s_axis_tx_tlast, s_axis_tx_tvalid, tx_src_dsc  out  1  framing and discontinue to the PCIe core.
REQ-015 s_axis_tx_tready  in  1  core ready.
REQ-016 grant_cnt0, grant_cnt1  out  32  free-running grant counters, wrap at 2^32.

Function
REQ-017 FSM states: IDLE, GNT0, GNT1; state register reset to IDLE.
REQ-018 IDLE: one req -> grant it next cycle. Both req -> grant the source not granted last; the last-granted flag resets to 1, so src0 wins the first tie.
REQ-019 Entering GNTn sets srcn_ack=1 on the same edge; ack latency is exactly one cycle after req is sampled.
REQ-020 In GNTn, the outputs to the core are a combinational mux of source n; srcn_tready = s_axis_tx_tready; the other source's tready = 0.
REQ-021 In IDLE, s_axis_tx_tvalid, tlast, tkeep, tdata, tx_src_dsc and both tready outputs are 0.
REQ-022 in_pkt flag: set on a tvalid&tready beat with tlast=0; cleared on a tvalid&tready beat with tlast=1.
REQ-023 GNTn -> IDLE when srcn_req=0 and in_pkt=0 (after beat update); srcn_ack drops on the same edge. Grant is never revoked mid-packet, even if req drops.
REQ-024 Direct GNTn -> GNTm is forbidden; there is always one IDLE cycle between grants.
REQ-025 srcN_other_req = registered value of the other source's req, updated every cycle regardless of state.
REQ-026 grant_cntN increments by 1 on each IDLE -> GNTN transition.
REQ-027 When req and a completing tlast beat occur in the same cycle, the grant is held. After the source deasserts req, release follows REQ-023.

Reset
REQ-028 On sys_rst: state=IDLE, in_pkt=0, last-granted=1, all acks=0, other_req=0, counters=0, all core-side outputs=0. Effect is immediate, no clock needed.
REQ-029 Reset mid-packet abandons the packet without emitting tlast; recovery begins in IDLE on the first clock after deassertion.

Structure
REQ-030 State encodings (IDLE=2'd0, GNT0=2'd1, GNT1=2'd2) and the source-index constants belong in the shared PCIe package.
REQ-031 A single sub-module, pcie_tx_mux, SHALL hold the combinational data/tready mux; the FSM, flags and counters stay in pcie_tx_arb.

Verification
REQ-032 src1_req=1 alone, tready=1 -> src1_ack=1 one cycle later. A 5-beat packet passes unchanged; grant_cnt1=1.
REQ-033 src0_req and src1_req rise together after reset -> src0 granted first. After src0 releases: one IDLE cycle, then src1 granted.
REQ-034 src1 drops req after beat 2 of a 5-beat packet -> ack held until the tlast beat, then IDLE the next cycle.
REQ-035 tready=0 for 3 cycles mid-packet -> the granted source sees tready=0. No beat is duplicated or lost; the other source's tready stays 0.
REQ-036 src0_req=1 while src1 holds the grant -> src1_other_req=1 one cycle later; src0 is granted only after src1 finishes.
REQ-037 sys_rst pulsed during beat 3 -> all outputs 0 immediately, state=IDLE. A new request after reset is granted in one cycle.
